decode_stage: RTL



---
 rtl/decode_stage_if.sv | 44 ++++
 rtl/decode_stage.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
`timescale 1ns/1ps
// Fetch -> decode -> execute handshake bundle, plus the writeback and flush
// signals that execute returns to decode.
interface decode_stage_if #(
  parameter int unsigned REG_INDEX_WIDTH = 4,
  parameter int unsigned DATA_BIT_WIDTH  = 32,
  parameter int unsigned INST_BIT_WIDTH  = 32,
  parameter int unsigned IMM_BIT_WIDTH   = 16
);
  logic                       in_valid;
  logic                       in_ready;
  logic [INST_BIT_WIDTH-1:0]  inst;
  logic [DATA_BIT_WIDTH-1:0]  in_pc;
  logic                       out_valid;
  logic                       out_ready;
  logic [DATA_BIT_WIDTH-1:0]  out_pc;
  logic [4:0]                 alu_fn;
  logic [REG_INDEX_WIDTH-1:0] src_reg1;
  logic [REG_INDEX_WIDTH-1:0] src_reg2;
  logic [REG_INDEX_WIDTH-1:0] dest_reg;
  logic [IMM_BIT_WIDTH-1:0]   imm;
  logic [1:0]                 sel_alu_sr2;
  logic [1:0]                 sel_reg_din;
  logic                       wr_reg;
  logic                       wr_mem;
  logic                       is_branch;
  logic                       is_jump;
  logic                       illegal;
  logic                       wb_valid;
  logic [REG_INDEX_WIDTH-1:0] wb_reg;
  logic                       flush;

  modport slave (
    input  in_valid, inst, in_pc, out_ready, wb_valid, wb_reg, flush,
    output in_ready, out_valid, out_pc, alu_fn, src_reg1, src_reg2, dest_reg,
           imm, sel_alu_sr2, sel_reg_din, wr_reg, wr_mem, is_branch, is_jump, illegal
  );

  modport master (
    output in_valid, inst, in_pc, out_ready, wb_valid, wb_reg, flush,
    input  in_ready, out_valid, out_pc, alu_fn, src_reg1, src_reg2, dest_reg,
           imm, sel_alu_sr2, sel_reg_din, wr_reg, wr_mem, is_branch, is_jump, illegal
  );
endinterface

// File: rtl/decode_stage.sv
`timescale 1ns/1ps
// Instruction decode stage: registered ID/EX slot with valid/ready handshakes and a
// per-register pending-write scoreboard that stalls read-after-write hazards.
module decode_stage #(
  parameter int unsigned REG_INDEX_WIDTH = 4,
  parameter int unsigned DATA_BIT_WIDTH  = 32,
  parameter int unsigned INST_BIT_WIDTH  = 32,
  parameter int unsigned IMM_BIT_WIDTH   = 16,
  parameter int unsigned PEND_W          = 2
) (
  input logic           clk,
  input logic           rst_n,
  decode_stage_if.slave dec
);
  localparam int unsigned       NREG    = 2 ** REG_INDEX_WIDTH;
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  localparam logic [3:0] OP_ALUR  = 4'hC;
  localparam logic [3:0] OP_ALUI  = 4'h4;
  localparam logic [3:0] OP_CMPR  = 4'hD;
  localparam logic [3:0] OP_CMPI  = 4'h5;
  localparam logic [3:0] OP_BCOND = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h7;
  localparam logic [3:0] OP_LW    = 4'h3;
  localparam logic [3:0] OP_JAL   = 4'hB;
  localparam logic [3:0] FN_ADD   = 4'h7;
  localparam logic [3:0] FN_MVHI  = 4'hB;
  localparam logic [15:0] BUBBLE  = 16'hDEAD;

  localparam logic [1:0] ALU_SRC2_REG2 = 2'd0;
  localparam logic [1:0] ALU_SRC2_IMM  = 2'd1;
  localparam logic [1:0] ALU_SRC2_IMM4 = 2'd2;
  localparam logic [1:0] ALU_SRC2_ZERO = 2'd3;
  localparam logic [1:0] REG_IN_ALU    = 2'd0;
  localparam logic [1:0] REG_IN_DOUT   = 2'd1;
  localparam logic [1:0] REG_IN_PC4    = 2'd2;
  localparam logic [1:0] REG_IN_IMM    = 2'd3;

  logic [3:0]                 w_fn, w_op;
  logic [REG_INDEX_WIDTH-1:0] w_s1, w_s2, w_rd;
  logic [4:0]                 w_alu_fn;
  logic [1:0]                 w_sel2, w_seli;
  logic                       w_wr_reg, w_wr_mem, w_br, w_jp, w_ill, w_use1, w_use2;
  logic [PEND_W-1:0]          w_cnt_s1, w_cnt_s2, w_cnt_rd;
  logic                       w_hazard, w_in_ready, w_accept, w_flush_kill;

  logic [PEND_W-1:0]          r_cnt [NREG];
  logic                       r_out_valid;
  logic [DATA_BIT_WIDTH-1:0]  r_pc;
  logic [4:0]                 r_alu_fn;
  logic [REG_INDEX_WIDTH-1:0] r_s1, r_s2, r_rd;
  logic [IMM_BIT_WIDTH-1:0]   r_imm;
  logic [1:0]                 r_sel2, r_seli;
  logic                       r_wr_reg, r_wr_mem, r_br, r_jp, r_ill;

  // Field extraction and control decode of the offered instruction.
  always_comb begin
    w_fn     = dec.inst[31:28];
    w_op     = dec.inst[27:24];
    w_rd     = REG_INDEX_WIDTH'(dec.inst[3:0]);
    w_s1     = REG_INDEX_WIDTH'(dec.inst[7:4]);
    w_s2     = REG_INDEX_WIDTH'(dec.inst[11:8]);
    w_alu_fn = '0;
    w_sel2   = ALU_SRC2_REG2;
    w_seli   = REG_IN_ALU;
    w_wr_reg = 1'b0;
    w_wr_mem = 1'b0;
    w_br     = 1'b0;
    w_jp     = 1'b0;
    w_ill    = 1'b0;
    w_use1   = 1'b0;
    w_use2   = 1'b0;
    if (w_op == OP_SW || w_op == OP_BCOND) begin
      w_s1 = REG_INDEX_WIDTH'(dec.inst[3:0]);
      w_s2 = REG_INDEX_WIDTH'(dec.inst[7:4]);
    end
    if (dec.inst[15:0] != BUBBLE) begin
      case (w_op)
        OP_ALUR, OP_CMPR: begin
          w_alu_fn = {w_op == OP_CMPR, w_fn};
          w_wr_reg = 1'b1;
          w_use1   = 1'b1;
          w_use2   = 1'b1;
        end
        OP_ALUI, OP_CMPI: begin
          w_alu_fn = {w_op == OP_CMPI, w_fn};
          w_sel2   = ALU_SRC2_IMM;
          w_seli   = (w_op == OP_ALUI && w_fn == FN_MVHI) ? REG_IN_IMM : REG_IN_ALU;
          w_wr_reg = 1'b1;
          w_use1   = 1'b1;
        end
        OP_LW: begin
          w_alu_fn = {1'b0, FN_ADD};
          w_sel2   = ALU_SRC2_IMM;
          w_seli   = REG_IN_DOUT;
          w_wr_reg = 1'b1;
          w_use1   = 1'b1;
        end
        OP_SW: begin
          w_alu_fn = {1'b0, FN_ADD};
          w_sel2   = ALU_SRC2_IMM;
          w_wr_mem = 1'b1;
          w_use1   = 1'b1;
          w_use2   = 1'b1;
        end
        OP_JAL: begin
          w_alu_fn = {1'b0, FN_ADD};
          w_sel2   = ALU_SRC2_IMM4;
          w_seli   = REG_IN_PC4;
          w_wr_reg = 1'b1;
          w_jp     = 1'b1;
          w_use1   = 1'b1;
        end
        OP_BCOND: begin
          w_br   = 1'b1;
          w_use1 = 1'b1;
          // Compare-against-zero forms fold into the comparator encodings.
          if (w_fn[3:2] == 2'b01) begin
            w_alu_fn = {3'b100, w_fn[1:0]};
            w_sel2   = ALU_SRC2_ZERO;
          end else if (w_fn[3:2] == 2'b10) begin
            w_alu_fn = {3'b111, w_fn[1:0]};
            w_sel2   = ALU_SRC2_ZERO;
          end else begin
            w_alu_fn = {1'b1, w_fn};
            w_use2   = 1'b1;
          end
        end
        default: w_ill = 1'b1;
      endcase
    end
  end

  // Hazard check sees pending counts net of this cycle's writeback, so retirement releases a stall immediately.
  always_comb begin
    w_cnt_s1 = r_cnt[w_s1] - PEND_W'(dec.wb_valid && (dec.wb_reg == w_s1));
    w_cnt_s2 = r_cnt[w_s2] - PEND_W'(dec.wb_valid && (dec.wb_reg == w_s2));
    w_cnt_rd = r_cnt[w_rd] - PEND_W'(dec.wb_valid && (dec.wb_reg == w_rd));
    w_hazard = dec.in_valid && ((w_use1 && (w_cnt_s1 != '0)) ||
                                (w_use2 && (w_cnt_s2 != '0)) ||
                                (w_wr_reg && (w_cnt_rd == CNT_MAX)));
  end

  assign w_in_ready   = !dec.flush && !w_hazard && (!r_out_valid || dec.out_ready);
  assign w_accept     = dec.in_valid && w_in_ready;
  assign w_flush_kill = dec.flush && r_out_valid && r_wr_reg;

  // Pending-write counters: accept adds, writeback and flushed writer subtract.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        r_cnt[i] <= r_cnt[i]
                  + PEND_W'(w_accept && w_wr_reg && (w_rd == REG_INDEX_WIDTH'(i)))
                  - PEND_W'(dec.wb_valid && (dec.wb_reg == REG_INDEX_WIDTH'(i)))
                  - PEND_W'(w_flush_kill && (r_rd == REG_INDEX_WIDTH'(i)));
      end
    end
  end

  // ID/EX register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_pc        <= '0;
      r_alu_fn    <= '0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_rd        <= '0;
      r_imm       <= '0;
      r_sel2      <= '0;
      r_seli      <= '0;
      r_wr_reg    <= 1'b0;
      r_wr_mem    <= 1'b0;
      r_br        <= 1'b0;
      r_jp        <= 1'b0;
      r_ill       <= 1'b0;
    end else if (dec.flush) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_pc        <= dec.in_pc;
      r_alu_fn    <= w_alu_fn;
      r_s1        <= w_s1;
      r_s2        <= w_s2;
      r_rd        <= w_rd;
      r_imm       <= IMM_BIT_WIDTH'(dec.inst[23:8]);
      r_sel2      <= w_sel2;
      r_seli      <= w_seli;
      r_wr_reg    <= w_wr_reg;
      r_wr_mem    <= w_wr_mem;
      r_br        <= w_br;
      r_jp        <= w_jp;
      r_ill       <= w_ill;
    end else if (dec.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign dec.in_ready    = w_in_ready;
  assign dec.out_valid   = r_out_valid;
  assign dec.out_pc      = r_pc;
  assign dec.alu_fn      = r_alu_fn;
  assign dec.src_reg1    = r_s1;
  assign dec.src_reg2    = r_s2;
  assign dec.dest_reg    = r_rd;
  assign dec.imm         = r_imm;
  assign dec.sel_alu_sr2 = r_sel2;
  assign dec.sel_reg_din = r_seli;
  assign dec.wr_reg      = r_wr_reg;
  assign dec.wr_mem      = r_wr_mem;
  assign dec.is_branch   = r_br;
  assign dec.is_jump     = r_jp;
  assign dec.illegal     = r_ill;
endmodule
